pe1_feeder: RTL and testbench

PE1_FEEDER -- requirements
Module: pe1_feeder

---
 rtl/pe1_feeder.sv | 219 +++++++++++++++++++++
 tb/tb_pe1_feeder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe1_feeder.sv
// Pairs a coefficient stream into (u,v) butterfly operands, tracks results through a
// fixed-latency PE and returns them in issue order via a credit-protected result FIFO.
module pe1_feeder #(
    parameter int DATA_WIDTH  = 14,
    parameter int PE_LAT      = 6,
    parameter int FIFO_DEPTH  = 8,
    parameter int BLOCK_PAIRS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] u,
    output logic [DATA_WIDTH-1:0] v,
    output logic                  sel,
    output logic                  issue,
    input  logic [DATA_WIDTH-1:0] bf_upper,
    input  logic [DATA_WIDTH-1:0] bf_lower,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_upper,
    output logic [DATA_WIDTH-1:0] out_lower,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = $clog2(BLOCK_PAIRS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int EW = 2 * DATA_WIDTH;

    localparam logic [PW-1:0] PAIRS_MAX = PW'(BLOCK_PAIRS);
    localparam logic [PW-1:0] ONE_P     = PW'(1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [CW-1:0] ZERO_C    = CW'(0);
    localparam logic [AW-1:0] ONE_A     = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    sel_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    hold_full_q;
    logic                    issue_q;
    logic [DATA_WIDTH-1:0]   hold_q;
    logic [DATA_WIDTH-1:0]   u_q;
    logic [DATA_WIDTH-1:0]   v_q;
    logic [PW-1:0]           pairs_q;
    logic [PW-1:0]           pairs_d;
    logic [CW-1:0]           in_flight_q;
    logic [CW-1:0]           in_flight_d;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           count_d;
    logic [PE_LAT-1:0]       sr_q;
    logic [PE_LAT-1:0]       sr_d;
    logic [AW-1:0]           wr_ptr_q;
    logic [AW-1:0]           rd_ptr_q;
    logic [EW-1:0]           mem_q [FIFO_DEPTH];
    logic [EW-1:0]           head_s;

    logic start_ok_s;
    logic credit_s;
    logic in_ready_s;
    logic accept_s;
    logic odd_acc_s;
    logic fifo_wr_s;
    logic fifo_rd_s;
    logic fifo_ne_s;

    // Handshake, credit and next-state arithmetic for counters and the latency line
    always_comb begin
        start_ok_s = (state_q == S_IDLE) && start;
        fifo_ne_s  = (count_q != ZERO_C);
        fifo_wr_s  = sr_q[PE_LAT-1];
        fifo_rd_s  = fifo_ne_s && out_ready;
        // Every formed pair not yet popped owns a FIFO slot, so the FIFO cannot overflow
        credit_s   = (in_flight_q + count_q + {{(CW-1){1'b0}}, issue_q}) < DEPTH_C;
        in_ready_s = (state_q == S_RUN) && (pairs_q < PAIRS_MAX) && (!hold_full_q || credit_s);
        accept_s   = in_valid && in_ready_s;
        odd_acc_s  = accept_s && hold_full_q;
        head_s     = mem_q[rd_ptr_q];

        sr_d    = sr_q;
        sr_d[0] = issue_q;
        for (int i = 1; i < PE_LAT; i++) begin
            sr_d[i] = sr_q[i-1];
        end

        case ({issue_q, fifo_wr_s})
            2'b10:   in_flight_d = in_flight_q + ONE_C;
            2'b01:   in_flight_d = in_flight_q - ONE_C;
            default: in_flight_d = in_flight_q;
        endcase

        case ({fifo_wr_s, fifo_rd_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        if (start_ok_s) begin
            pairs_d = {PW{1'b0}};
        end else if (odd_acc_s) begin
            pairs_d = pairs_q + ONE_P;
        end else begin
            pairs_d = pairs_q;
        end
    end

    // Block sequencing FSM with registered sel/busy/done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        sel_q   <= mode;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (pairs_q == PAIRS_MAX) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((in_flight_q == ZERO_C) && !fifo_ne_s && !issue_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operand pairing, issue pulse, latency line, in-flight and FIFO bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q      <= {DATA_WIDTH{1'b0}};
            hold_full_q <= 1'b0;
            u_q         <= {DATA_WIDTH{1'b0}};
            v_q         <= {DATA_WIDTH{1'b0}};
            issue_q     <= 1'b0;
            pairs_q     <= {PW{1'b0}};
            in_flight_q <= ZERO_C;
            count_q     <= ZERO_C;
            sr_q        <= {PE_LAT{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
        end else begin
            issue_q     <= odd_acc_s;
            pairs_q     <= pairs_d;
            in_flight_q <= in_flight_d;
            count_q     <= count_d;
            sr_q        <= sr_d;
            if (start_ok_s) begin
                hold_full_q <= 1'b0;
            end else if (accept_s && !hold_full_q) begin
                hold_q      <= in_data;
                hold_full_q <= 1'b1;
            end else if (odd_acc_s) begin
                u_q         <= hold_q;
                v_q         <= in_data;
                hold_full_q <= 1'b0;
            end
            if (fifo_wr_s) begin
                wr_ptr_q <= wr_ptr_q + ONE_A;
            end
            if (fifo_rd_s) begin
                rd_ptr_q <= rd_ptr_q + ONE_A;
            end
        end
    end

    // Result storage; contents are only observable through a valid head
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            mem_q[wr_ptr_q] <= {bf_upper, bf_lower};
        end
    end

    assign in_ready  = in_ready_s;
    assign u         = u_q;
    assign v         = v_q;
    assign sel       = sel_q;
    assign issue     = issue_q;
    assign out_valid = fifo_ne_s;
    assign out_upper = fifo_ne_s ? head_s[EW-1:DATA_WIDTH] : {DATA_WIDTH{1'b0}};
    assign out_lower = fifo_ne_s ? head_s[DATA_WIDTH-1:0]  : {DATA_WIDTH{1'b0}};
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pe1_feeder.sv
// Randomized bench for pe1_feeder: behavioural butterfly PE plus a pair/result scoreboard.
module tb_pe1_feeder;

    localparam int          DW     = 14;
    localparam int          PE_LAT = 6;
    localparam int          DEPTH  = 8;
    localparam int          BP     = 16;
    localparam int unsigned Q      = 12289;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, mode, in_valid, in_ready, sel, issue;
    logic [DW-1:0] in_data, u, v, bf_upper, bf_lower, out_upper, out_lower;
    logic          out_valid, out_ready, busy, done;

    pe1_feeder #(.DATA_WIDTH(DW), .PE_LAT(PE_LAT), .FIFO_DEPTH(DEPTH), .BLOCK_PAIRS(BP)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .u(u), .v(v), .sel(sel), .issue(issue),
        .bf_upper(bf_upper), .bf_lower(bf_lower),
        .out_valid(out_valid), .out_upper(out_upper), .out_lower(out_lower), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int unsigned half_q(input int unsigned x);
        return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
    endfunction

    function automatic logic [2*DW-1:0] bfly(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m);
        int unsigned x, y, up, lo;
        x = a;
        y = b;
        if (!m) begin
            up = (x + Q - y) % Q;
            lo = (x + y) % Q;
        end else begin
            up = half_q((y + Q - x) % Q);
            lo = half_q((x + y) % Q);
        end
        return {up[DW-1:0], lo[DW-1:0]};
    endfunction

    // Behavioural PE: fixed PE_LAT pipeline, garbage on the bus when nothing is due
    logic [2*DW:0] pipe [PE_LAT];
    logic [DW-1:0] junk_u, junk_l;
    always @(posedge clk) begin
        for (int i = PE_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= {issue, bfly(u, v, sel)};
        junk_u  <= DW'($urandom);
        junk_l  <= DW'($urandom);
    end
    assign bf_upper = pipe[PE_LAT-1][2*DW] ? pipe[PE_LAT-1][2*DW-1:DW] : junk_u;
    assign bf_lower = pipe[PE_LAT-1][2*DW] ? pipe[PE_LAT-1][DW-1:0]    : junk_l;

    typedef struct packed {logic [DW-1:0] u, v, up, lo;} pair_t;
    typedef struct packed {int t; logic [DW-1:0] up, lo;} res_t;

    pair_t         pair_q[$];
    res_t          res_q[$];
    logic [DW-1:0] dir_q[$];
    logic [DW-1:0] hold_v;
    int            n_checks = 0, n_errors = 0;
    int            cyc = 0, acc = 0, formed = 0, popped = 0, n_issue = 0, done_cnt = 0;
    int            p_valid = 0, p_ready = 0;
    bit            m_busy = 1'b0, m_sel = 1'b0, pend_issue = 1'b0;
    bit            start_req = 1'b0, start_mode = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_u"}, 32'(u), 32'd0);
        check_eq({tag, "_v"}, 32'(v), 32'd0);
        check_eq({tag, "_sel"}, 32'(sel), 32'd0);
        check_eq({tag, "_issue"}, 32'(issue), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_out_upper"}, 32'(out_upper), 32'd0);
        check_eq({tag, "_out_lower"}, 32'(out_lower), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic clear_model();
        pair_q.delete();
        res_q.delete();
        dir_q.delete();
        m_busy = 1'b0; m_sel = 1'b0; pend_issue = 1'b0;
        acc = 0; formed = 0; popped = 0; n_issue = 0; done_cnt = 0;
    endtask

    // One cycle: observe and check at the falling edge, then drive the next inputs
    task automatic step();
        bit            exp_ir, go_idle, set_busy, odd;
        int            avail;
        pair_t         p;
        res_t          r;
        logic [2*DW-1:0] b;
        @(negedge clk);
        cyc++;
        exp_ir = m_busy && (acc < 2 * BP) && ((acc % 2 == 0) || (formed - popped < DEPTH));
        check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
        check_eq("issue", 32'(issue), 32'(pend_issue));
        check_eq("sel", 32'(sel), 32'(m_sel));
        check_eq("busy", 32'(busy), 32'(m_busy));
        if (issue) begin
            if (pair_q.size() == 0) begin
                check_eq("issue_unexpected", 32'd1, 32'd0);
            end else begin
                p = pair_q.pop_front();
                check_eq("u", 32'(u), 32'(p.u));
                check_eq("v", 32'(v), 32'(p.v));
                res_q.push_back('{t: cyc + PE_LAT + 1, up: p.up, lo: p.lo});
                n_issue++;
            end
        end
        avail = 0;
        foreach (res_q[i]) if (res_q[i].t <= cyc) avail++;
        check_eq("out_valid", 32'(out_valid), 32'(avail > 0));
        go_idle = 1'b0;
        if (done) begin
            check_eq("done_state", {29'd0, m_busy, (formed == popped), (acc == 2 * BP)}, 32'd7);
            done_cnt++;
            go_idle = 1'b1;
        end

        out_ready = ($urandom_range(0, 99) < p_ready);
        if (out_valid && out_ready) begin
            if (res_q.size() == 0) begin
                check_eq("pop_unexpected", 32'd1, 32'd0);
            end else begin
                r = res_q.pop_front();
                check_eq("out_upper", 32'(out_upper), 32'(r.up));
                check_eq("out_lower", 32'(out_lower), 32'(r.lo));
                popped++;
            end
        end

        if (dir_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = dir_q[0];
        end else begin
            in_valid = ($urandom_range(0, 99) < p_valid);
            in_data  = DW'($urandom_range(0, Q - 1));
        end
        odd        = (acc % 2 == 1);
        pend_issue = 1'b0;
        if (in_valid && in_ready) begin
            if (dir_q.size() > 0) void'(dir_q.pop_front());
            if (!odd) begin
                hold_v = in_data;
            end else begin
                b = bfly(hold_v, in_data, m_sel);
                pair_q.push_back('{u: hold_v, v: in_data, up: b[2*DW-1:DW], lo: b[DW-1:0]});
                formed++;
                pend_issue = 1'b1;
            end
            acc++;
        end

        set_busy = 1'b0;
        start    = 1'b0;
        mode     = 1'($urandom);
        if (start_req) begin
            start     = 1'b1;
            mode      = start_mode;
            start_req = 1'b0;
            if (!m_busy) begin
                m_sel = start_mode;
                set_busy = 1'b1;
                acc = 0; formed = 0; popped = 0; n_issue = 0; done_cnt = 0;
            end
        end
        if (go_idle)  m_busy = 1'b0;
        if (set_busy) m_busy = 1'b1;
    endtask

    task automatic begin_block(input bit m);
        start_req  = 1'b1;
        start_mode = m;
        step();
    endtask

    task automatic finish_block(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            step();
            k++;
        end
        if (done_cnt == 0) check_eq("done_timeout", 32'd0, 32'd1);
        step();
        check_eq("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        rst = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) step();

        // mode 0 with leading pair 5,3 -> (2,8)
        p_valid = 70; p_ready = 80;
        dir_q.push_back(14'd5); dir_q.push_back(14'd3);
        begin_block(1'b0);
        finish_block(2000);

        // mode 1 with leading pair 5,3 -> (12288,4)
        dir_q.push_back(14'd5); dir_q.push_back(14'd3);
        begin_block(1'b1);
        finish_block(2000);

        // consumer stalled: FIFO fills, input throttled by credit
        p_valid = 100; p_ready = 0;
        begin_block(1'b0);
        repeat (60) step();
        check_eq("stall_pairs", 32'(formed), 32'(DEPTH));
        check_eq("stall_accepts", 32'(acc), 32'(2 * DEPTH + 1));
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        check_eq("stall_out_valid", 32'(out_valid), 32'd1);
        p_ready = 100;
        finish_block(2000);

        // start and mode activity mid-block are ignored
        p_valid = 60; p_ready = 60;
        begin_block(1'b1);
        repeat (10) step();
        repeat (6) begin
            start_req  = 1'b1;
            start_mode = 1'($urandom);
            step();
        end
        finish_block(2000);
        check_eq("sel_kept", 32'(sel), 32'd1);

        // continuous streaming
        p_valid = 100; p_ready = 100;
        begin_block(1'b0);
        finish_block(2000);
        check_eq("cont_accepts", 32'(acc), 32'(2 * BP));
        check_eq("cont_issues", 32'(n_issue), 32'(BP));
        check_eq("cont_results", 32'(popped), 32'(BP));
        check_eq("cont_done_pulses", 32'(done_cnt), 32'd1);

        repeat (3) begin
            p_valid = $urandom_range(30, 100);
            p_ready = $urandom_range(10, 100);
            begin_block(1'($urandom));
            finish_block(3000);
        end

        // reset mid-block with three pairs in flight
        p_valid = 100; p_ready = 0;
        begin_block(1'b0);
        k = 0;
        while (formed < 3 && k < 100) begin
            step();
            k++;
        end
        p_valid = 0;
        repeat (2) step();
        check_eq("pre_reset_pairs", 32'(formed), 32'd3);
        #2 rst = 1'b0;
        #1 check_zero_outputs("mid_reset");
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        p_valid = 100; p_ready = 100;
        repeat (20) step();
        check_eq("post_reset_no_output", 32'(out_valid), 32'd0);

        p_valid = 80; p_ready = 80;
        begin_block(1'b1);
        finish_block(2000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
